// File: rtl/ram_burst_master_if.sv
// rtl/ram_burst_master_if.sv - command, write-data, read-data and RAM-side signals of ram_burst_master
// Ports (master = burst engine view):
//   cmd_*    : burst command channel (valid/ready), write flag, start address, length
//   wr_*     : write-data stream into the engine (valid/ready)
//   rd_*     : read-data stream out of the engine (valid/ready)
//   busy/done: status, done pulses once per completed burst
//   mem_*    : single-port synchronous RAM strobes, address, data
interface ram_burst_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
           mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - burst initiator for a single-port RAM with 1-cycle registered read
// Ports:
//   clk   : clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : ram_burst_master_if.master (command, write stream, read stream, status, RAM side)
module ram_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_burst_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic [DATA_W-1:0] rbuf [2];
  logic              head;
  logic [1:0]        occ;

  logic              cmd_hs;
  logic              wr_hs;
  logic              pop;
  logic              issue;
  logic [2:0]        occ_sum;
  logic [1:0]        occ_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    cmd_hs  = (state == IDLE) && bus.cmd_valid;
    wr_hs   = (state == WRITE) && bus.wr_valid;
    pop     = (occ != 2'd0) && bus.rd_ready;
    // Buffer occupancy at the end of this cycle, counting the word landing from last cycle's read.
    occ_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    occ_nxt = occ_sum[1:0];
    // Issuing only while fewer than 2 words are committed keeps the 2-deep buffer from overflowing.
    issue   = (state == READ) && (remaining != '0) && (occ_sum < 3'd2);

    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (bus.cmd_len == '0)  state_nxt = DONE;
          else if (bus.cmd_write) state_nxt = WRITE;
          else                    state_nxt = READ;
        end
      end
      WRITE: begin
        if (wr_hs && (remaining == LEN_W'(1))) state_nxt = DONE;
      end
      READ: begin
        if ((remaining == '0) && !inflight && (occ_nxt == 2'd0)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // cmd_ready is gated by rst_n so it reads 0 while reset is held.
    bus.cmd_ready = (state == IDLE) && rst_n;
    bus.wr_ready  = (state == WRITE);
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.mem_wr_en = wr_hs;
    bus.mem_wdata = (state == WRITE) ? bus.wr_data : '0;
    bus.mem_rd_en = issue;
    bus.mem_addr  = addr;
    bus.rd_valid  = (occ != 2'd0);
    bus.rd_data   = (occ != 2'd0) ? rbuf[head] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      rbuf[0]   <= '0;
      rbuf[1]   <= '0;
      head      <= 1'b0;
      occ       <= 2'd0;
    end else begin
      inflight <= issue;
      if (cmd_hs) begin
        addr      <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (wr_hs || issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      // Tail slot is head+occ mod 2; when occ==2 that is the head slot, which is popping this cycle.
      if (inflight) rbuf[head ^ occ[0]] <= bus.mem_rdata;
      if (pop) head <= ~head;
      occ <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb/tb_ram_burst_master.sv - self-checking bench for ram_burst_master
module tb_ram_burst_master;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ram_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  bit pat6 [6] = '{1, 0, 1, 1, 0, 1};
  bit pat4 [4] = '{1, 0, 0, 1};

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  function automatic logic [31:0] seed_word(input int i);
    return 32'h5A00_C3C3 ^ (32'(i) << 16) ^ 32'(i * 7);
  endfunction

  // RAM macro model: 1-cycle registered read, contents reloaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed_word(i);
    end else begin
      if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic reload_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_wr_ready"},  bus.wr_ready, 0);
    chk({tag, "_rd_valid"},  bus.rd_valid, 0);
    chk({tag, "_rd_data"},   bus.rd_data, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_strobes"},   {bus.mem_rd_en, bus.mem_wr_en}, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // Runs one burst from IDLE through done; expectations come from ref_mem and burst arithmetic.
  // vmode/rmode: 0 = always 1, 1 = random, 2 = fixed gap/backpressure pattern.
  task automatic do_burst(input bit wr, input logic [7:0] a, input int len, input int dbase,
                          input int vmode, input int rmode, input bit spam, input bit chk_t,
                          input int exp_first, input int exp_done);
    logic [31:0] wdata [256];
    logic [31:0] expq [$];
    int          sent, issued, popped, first_c, done_c, budget;
    bit          stalled, wv, rr;
    logic [31:0] held;
    logic [7:0]  ea;

    for (int i = 0; i < len; i++) begin
      wdata[i] = (dbase >= 0) ? 32'(dbase + i) : $urandom;
      ea = a + 8'(i);
      if (wr) ref_mem[ea] = wdata[i];
      else    expq.push_back(ref_mem[ea]);
    end

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = LEN_W'(len);
    #1;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge clk); #1;

    sent = 0; issued = 0; popped = 0; first_c = -1; done_c = -1;
    stalled = 1'b0; held = '0;
    budget = len * 12 + 40;
    for (int c = 1; c <= budget; c++) begin
      wv = 1'b0;
      if (wr && sent < len) begin
        case (vmode)
          0:       wv = 1'b1;
          1:       wv = 1'($urandom_range(0, 1));
          default: wv = pat6[(c - 1) % 6];
        endcase
      end
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(0, 1));
        default: rr = pat4[(c - 1) % 4];
      endcase
      bus.wr_valid = wv;
      bus.wr_data  = wv ? wdata[sent] : $urandom;
      bus.rd_ready = rr;
      if (spam && sent < len) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h77;
        bus.cmd_len   = 9'd3;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      #1;
      chk("strobe_overlap", bus.mem_wr_en & bus.mem_rd_en, 0);
      chk("busy", bus.busy, 1);
      if (spam) chk("cmd_ignored", bus.cmd_ready, 0);
      if (wr) begin
        chk("wr_ready", bus.wr_ready, sent < len);
        chk("mem_wr_en", bus.mem_wr_en, wv);
        chk("mem_rd_en_in_write", bus.mem_rd_en, 0);
        if (wv) begin
          ea = a + 8'(sent);
          chk("wr_addr", bus.mem_addr, ea);
          chk("wr_wdata", bus.mem_wdata, wdata[sent]);
          sent++;
        end
      end else begin
        chk("mem_wr_en_in_read", bus.mem_wr_en, 0);
        if (bus.mem_rd_en) begin
          ea = a + 8'(issued);
          chk("rd_addr", bus.mem_addr, ea);
          issued++;
          chk("rd_overissue", issued <= len, 1);
          chk("rd_outstanding", (issued - popped) <= 3, 1);
        end
        if (bus.rd_valid) begin
          if (first_c < 0) first_c = c;
          if (stalled) chk("rd_data_stable", bus.rd_data, held);
          if (rr) begin
            chk("rd_count", popped < len, 1);
            if (popped < len) chk("rd_data", bus.rd_data, expq[popped]);
            popped++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held = bus.rd_data;
          end
        end else begin
          stalled = 1'b0;
        end
      end
      if (bus.done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end

    chk("done_seen", done_c > 0, 1);
    chk("word_count", wr ? sent : popped, len);
    if (chk_t) chk("done_cycle", done_c, exp_done);
    if (chk_t && !wr && len > 0) chk("first_rd_valid_cycle", first_c, exp_first);

    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("cmd_ready_after", bus.cmd_ready, 1);
    chk("idle_after", bus.busy, 0);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    int         len;
    int         dbase;
    int         vmode;
    int         rmode;
    bit         spam;
    bit         chk_t;
    int         exp_first;
    int         exp_done;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit         rw;
    logic [7:0] ra;
    int         rl;

    // Cycle numbers count from the command-accept cycle (0): a write of L words at full rate
    // finishes at L+1; a read delivers its first word at 3 and finishes at L+3.
    vecs[0]  = '{1, 8'h10, 4, 'hA0, 0, 0, 0, 1, 0, 5};
    vecs[1]  = '{0, 8'h10, 4, -1,   0, 0, 0, 1, 3, 7};
    vecs[2]  = '{1, 8'hFE, 4, 1,    0, 0, 0, 1, 0, 5};
    vecs[3]  = '{0, 8'hFE, 4, -1,   0, 0, 0, 1, 3, 7};
    vecs[4]  = '{1, 8'h00, 0, -1,   0, 0, 0, 1, 0, 1};
    vecs[5]  = '{0, 8'h55, 0, -1,   0, 0, 0, 1, 0, 1};
    vecs[6]  = '{0, 8'h10, 1, -1,   0, 0, 0, 1, 3, 4};
    vecs[7]  = '{1, 8'h80, 1, -1,   0, 0, 0, 1, 0, 2};
    vecs[8]  = '{0, 8'hFE, 6, -1,   0, 2, 0, 0, 0, 0};
    vecs[9]  = '{1, 8'h20, 4, -1,   2, 0, 1, 1, 0, 7};
    vecs[10] = '{0, 8'h20, 4, -1,   0, 1, 0, 0, 0, 0};
    vecs[11] = '{0, 8'h12, 2, -1,   0, 0, 0, 1, 3, 5};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    reload_ref();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_post_reset", bus.cmd_ready, 1);
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++)
      do_burst(vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].dbase, vecs[k].vmode,
               vecs[k].rmode, vecs[k].spam, vecs[k].chk_t, vecs[k].exp_first, vecs[k].exp_done);

    // Reset while the third word of an 8-word read is on rd_data.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h30;
    bus.cmd_len   = 9'd8;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("abort_word3_valid", bus.rd_valid, 1);
    chk("abort_word3_data", bus.rd_data, ref_mem[8'h32]);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    reload_ref();
    #1;
    chk("abort_cmd_ready_release", bus.cmd_ready, 1);
    chk("abort_rd_valid_release", bus.rd_valid, 0);
    chk("abort_busy_release", bus.busy, 0);
    do_burst(1, 8'h30, 3, 'h300, 0, 0, 0, 1, 0, 4);
    do_burst(0, 8'h2F, 5, -1, 0, 0, 0, 1, 3, 8);

    // Full-range bursts: every address touched exactly once, wrapping through 0x00.
    do_burst(1, 8'h9C, 256, -1, 0, 0, 0, 1, 0, 257);
    do_burst(0, 8'h9C, 256, -1, 0, 0, 0, 1, 3, 259);
    do_burst(0, 8'h00, 256, -1, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rl = $urandom_range(0, 12);
      do_burst(rw, ra, rl, -1, 1, 1, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
